med_reminder_scanner: RTL

//  Consumer end of the medication table RAM: on each minute tick it walks all entries,

---
 rtl/med_reminder_scanner.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/med_reminder_scanner.sv
// Medication reminder scanner: on every minute tick it walks the medication
// table, decrements each live countdown, writes it back and raises a
// handshaked alert carrying the MedID whenever a countdown reaches zero.
// The RAM ports belong to this block only while Busy is high.
module med_reminder_scanner #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Tick_In,
    output logic              Read_En,
    output logic [ADDR_W-1:0] R_Addr,
    input  logic [DATA_W-1:0] R_Data,
    output logic              Write_En,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              Alert_Valid,
    output logic [3:0]        Alert_MedID,
    input  logic              Alert_Ack,
    output logic              Busy,
    output logic              Tick_Overrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_EVAL  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_ALERT = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] idx;
    logic              tick_pend;
    logic [3:0]        rd_id;
    logic [3:0]        rd_time;
    logic              last_entry;
    logic              start_scan;
    logic              rescan;
    logic              busy_tick;

    assign rd_id      = R_Data[7:4];
    assign rd_time    = R_Data[3:0];
    assign last_entry = (idx == LAST_IDX);
    assign start_scan = (state == S_IDLE) && (Tick_In || tick_pend);
    assign rescan     = (state == S_NEXT) && last_entry && tick_pend;
    assign busy_tick  = Tick_In && (state != S_IDLE);

    // Strobes are gated by reset so an asserted reset suppresses the access
    // already underway in the same cycle.
    assign Read_En     = (state == S_READ) && !Rst;
    assign Write_En    = (state == S_WRITE) && !Rst;
    assign Alert_Valid = (state == S_ALERT);
    assign Busy        = (state != S_IDLE);

    // Main scan sequencer: walks every entry, registers the address and
    // write-back data on state entry so they hold steady outside READ/WRITE.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            R_Addr      <= '0;
            W_Addr      <= '0;
            W_Data      <= '0;
            Alert_MedID <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_scan) begin
                        state  <= S_READ;
                        idx    <= '0;
                        R_Addr <= '0;
                    end
                end
                S_READ: begin
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    if (rd_id == 4'd0 || rd_time == 4'd0) begin
                        state <= S_NEXT;
                    end else begin
                        state  <= S_WRITE;
                        W_Addr <= idx;
                        W_Data <= {rd_id, rd_time - 4'd1};
                    end
                end
                S_WRITE: begin
                    if (W_Data[3:0] == 4'd0) begin
                        state       <= S_ALERT;
                        Alert_MedID <= W_Data[7:4];
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_ALERT: begin
                    if (Alert_Ack) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (last_entry) begin
                        if (tick_pend) begin
                            state  <= S_READ;
                            idx    <= '0;
                            R_Addr <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        state  <= S_READ;
                        idx    <= idx + IDX_ONE;
                        R_Addr <= idx + IDX_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Tick bookkeeping: one tick may wait for the current scan to finish;
    // a further tick while one is already waiting is dropped and flagged.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            tick_pend    <= 1'b0;
            Tick_Overrun <= 1'b0;
        end else begin
            if (start_scan || rescan) begin
                tick_pend <= 1'b0;
            end else if (busy_tick) begin
                tick_pend <= 1'b1;
            end
            if (busy_tick && tick_pend) begin
                Tick_Overrun <= 1'b1;
            end
        end
    end

endmodule
